stim_sequencer: RTL
===================

Name: stim_sequencer

Overview:
Synthesizable, parametrised successor to the hand-written reset/stimulus sequence used in race testing. It drives a DUT reset pulse and then a programmable ramp of input values, each held for a run-time number of clock cycles. Supports one-shot and loop modes, abort, and step/phase status. It sits between the bench or on-chip controller and the DUT's rst/in ports. Every output is registered, so the DUT never sees a same-edge race.

Parameters:
WIDTH, 8, width of value output
STEPS, 4, number of ramp steps per pass (≥1)
RST_CYCLES, 2, cycles dut_rst is held high per pass (≥1)
GAP_CYCLES, 2, cycles between dut_rst release and first step, value=INIT_VALUE (≥1)
INIT_VALUE, 8'h00, value driven in IDLE/RST/GAP
BASE, 8'h02, value of step 0
INCR, 8'h01, increment per step
HOLD_W, 8, width of hold_cycles input

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a pass; sampled only in IDLE or DONE
loop_en  in  1  sampled with start; 1 = repeat passes until abort
abort  in  1  return to IDLE next edge from any state
hold_cycles  in  HOLD_W  cycles per step; sampled with start; 0 treated as 1
dut_rst  out  1  reset to DUT
value  out  WIDTH  stimulus value to DUT
step_idx  out  clog2(STEPS) (min 1)  current step index
busy  out  1  high in RST/GAP/RUN
done  out  1  one-cycle pulse on pass completion (one-shot only)

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, dut_rst=1, value=INIT_VALUE, step_idx=0, busy=0, done=0, counters=0. rst has priority over every other input.
- FSM states: IDLE, RST, GAP, RUN, DONE. All outputs are registered and change only on the edge that enters a state.
- IDLE:
  - dut_rst=1, value=INIT_VALUE.
  - start=1 → RST; latch loop_en and hold_cycles (0 → 1).
- RST:
  - dut_rst=1, busy=1.
  - Stays for RST_CYCLES cycles counted from the entering edge, then → GAP.
- GAP:
  - dut_rst=0, value=INIT_VALUE.
  - Stays for GAP_CYCLES cycles, then → RUN with step_idx=0.
- RUN:
  - value = BASE + step_idx*INCR, truncated to WIDTH (mod 2^WIDTH wrap, no saturation).
  - Each step is held for the latched hold count, then step_idx increments.
  - After the last step (STEPS-1) completes its hold: if latched loop=1 → RST (step_idx=0, new pass); otherwise → DONE.
- DONE:
  - busy=0, dut_rst=0, value holds the last step value, step_idx holds STEPS-1.
  - done=1 only on the cycle after entry.
  - start=1 → RST (new latch of loop_en/hold_cycles); otherwise remain in DONE.
- start while busy: ignored; changes to hold_cycles or loop_en mid-pass are ignored.
- abort=1 in any state:
  - next state IDLE, dut_rst=1, value=INIT_VALUE, step_idx=0, busy=0, no done pulse.
  - abort wins over simultaneous start.
- Loop mode never pulses done. Consecutive passes re-enter RST directly with no idle cycle.
- One-shot pass length = RST_CYCLES + GAP_CYCLES + STEPS*hold cycles of busy=1.
- rst asserted mid-pass behaves identically to power-on reset on the next edge.

Test Plan:
- Defaults, hold_cycles=4, start sampled at edge E0:
  - dut_rst=1 through E2.
  - value=00 with dut_rst=0 after E2..E3.
  - value=02/03/04/05 after E4/E8/E12/E16; step_idx 0..3.
  - DONE after E20; done=1 for exactly one cycle; busy=1 for exactly 20 cycles.
- Wrap: BASE=8'hFE, INCR=1, STEPS=4, hold=1 → values FE, FF, 00, 01 on consecutive cycles; done after 8 busy cycles.
- hold_cycles=0 → each step held exactly 1 cycle, identical to the hold=1 case. Changing hold_cycles to 7 mid-pass has no effect.
- Loop: loop_en=1 with start, hold=2:
  - after step 3 completes, dut_rst=1 again on the next edge; second pass is identical; done never asserts.
  - abort mid-RUN → next cycle IDLE, dut_rst=1, value=00, busy=0.
- Simultaneous events:
  - start pulsed during RUN is ignored.
  - start+abort in the same cycle during GAP → IDLE.
  - start in DONE → restarts, dut_rst=1 next cycle.
- rst=1 during RUN step 2 → next cycle all outputs at reset values; a subsequent start produces the full default sequence.

Source files
------------

// File: rtl/stim_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | stim_sequencer                                                         |
// | Registered DUT reset pulse followed by a held ramp of stimulus values. |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module stim_sequencer #(
    parameter int                WIDTH      = 8,
    parameter int                STEPS      = 4,
    parameter int                RST_CYCLES = 2,
    parameter int                GAP_CYCLES = 2,
    parameter logic [WIDTH-1:0]  INIT_VALUE = WIDTH'(0),
    parameter logic [WIDTH-1:0]  BASE       = WIDTH'(2),
    parameter logic [WIDTH-1:0]  INCR       = WIDTH'(1),
    parameter int                HOLD_W     = 8,
    localparam int               SW         = (STEPS > 1) ? $clog2(STEPS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              loop_en,
    input  logic              abort,
    input  logic [HOLD_W-1:0] hold_cycles,
    output logic              dut_rst,
    output logic [WIDTH-1:0]  value,
    output logic [SW-1:0]     step_idx,
    output logic              busy,
    output logic              done
);

    // Counter is one bit wider than anything it must reach, so the hold count zero-extends cleanly.
    localparam int CW_A = (HOLD_W > $clog2(RST_CYCLES + 1)) ? HOLD_W : $clog2(RST_CYCLES + 1);
    localparam int CW   = ((CW_A > $clog2(GAP_CYCLES + 1)) ? CW_A : $clog2(GAP_CYCLES + 1)) + 1;

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RST  = 3'd1,
        S_GAP  = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [HOLD_W-1:0] hold_lat;
    logic              loop_lat;
    logic [CW-1:0]     hold_last;

    assign hold_last = CW'(hold_lat) - CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            hold_lat <= '0;
            loop_lat <= 1'b0;
            dut_rst  <= 1'b1;
            value    <= INIT_VALUE;
            step_idx <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (abort) begin
            state    <= S_IDLE;
            cnt      <= '0;
            dut_rst  <= 1'b1;
            value    <= INIT_VALUE;
            step_idx <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_RST;
                        cnt      <= '0;
                        loop_lat <= loop_en;
                        // A zero hold would never expire, so it runs as a one-cycle hold.
                        hold_lat <= (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
                        dut_rst  <= 1'b1;
                        value    <= INIT_VALUE;
                        step_idx <= '0;
                        busy     <= 1'b1;
                    end
                end
                S_RST: begin
                    if (cnt == RST_LAST) begin
                        state   <= S_GAP;
                        cnt     <= '0;
                        dut_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state    <= S_RUN;
                        cnt      <= '0;
                        value    <= BASE;
                        step_idx <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RUN: begin
                    if (cnt == hold_last) begin
                        cnt <= '0;
                        if (step_idx == STEP_LAST) begin
                            if (loop_lat) begin
                                state    <= S_RST;
                                dut_rst  <= 1'b1;
                                value    <= INIT_VALUE;
                                step_idx <= '0;
                            end else begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            step_idx <= step_idx + SW'(1);
                            value    <= value + INCR;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    cnt      <= '0;
                    dut_rst  <= 1'b1;
                    value    <= INIT_VALUE;
                    step_idx <= '0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
